ahb_rr_arbiter: RTL
===================

// Module: ahb_rr_arbiter
// PURPOSE
//   Round-robin AHB bus arbiter for the 2-master/4-slave fabric.
//   - Grants one master at a time and holds the grant for fixed-length bursts and locked sequences.
//   - Tracks address-phase and data-phase ownership, masks SPLIT masters, and parks on a default master.
//   - Its hmaster output drives the master-side address/write-data muxes.
// PARAMETERS
//   NUM_MASTERS  2  number of requesting masters (2..4)
//   MW           1  width of master index = $clog2(NUM_MASTERS)
//   DEF_MASTER   0  master parked on when no request is pending
// PORTS
//   hclk       in   1            bus clock; all state on rising edge
//   hreset     in   1            synchronous, active-high reset
//   hbusreq    in   NUM_MASTERS  per-master bus request
//   hlock      in   NUM_MASTERS  per-master locked-transfer request
//   htrans     in   2            muxed HTRANS of current address-phase owner
//   hburst     in   3            muxed HBURST of current address-phase owner
//   hready     in   1            muxed slave HREADY
//   hresp      in   2            muxed slave HRESP (00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT)
//   hsplit     in   NUM_MASTERS  per-master split-resume pulses (OR of slaves)
//   hgrant     out  NUM_MASTERS  one-hot grant, registered
//   hmaster    out  MW           address-phase owner
//   hmaster_d  out  MW           data-phase owner (drives write-data/response mux)
//   hmastlock  out  1            current address phase is locked
// BEHAVIOUR
//   Reset values: hgrant = one-hot(DEF_MASTER), hmaster = hmaster_d = DEF_MASTER, hmastlock = 0,
//     FSM = ARB, split mask = 0, beat counter = 0. Reset mid-burst aborts all state.
//   Ownership pipeline: every state update below happens only on edges with hready = 1.
//     - hmaster    <= idx(hgrant)
//     - hmastlock  <= hlock[idx(hgrant)]
//     - hmaster_d  <= hmaster
//   Selection: eligible = hbusreq & ~split_mask.
//     - Pick the first eligible master searching from last_owner+1 upward, wrapping.
//     - If nothing is eligible, select DEF_MASTER, even if it is split-masked.
//   FSM states (hgrant may change only on hready = 1 edges, and only in ARB):
//     ARB    re-evaluate hgrant each hready edge. When owner's NONSEQ is accepted:
//            fixed burst (INCR4/8/16, WRAP4/8/16) -> BURST, load beats = len-1;
//            else hlock[owner] = 1 -> LOCK.
//            SINGLE and INCR (undefined length) stay in ARB.
//     BURST  decrement beats on each accepted SEQ. BUSY/IDLE beats: no decrement.
//            When beats reaches 1 (penultimate address accepted) -> ARB, so hgrant moves
//            while the final beat is presented. The owner dropping hbusreq is ignored.
//     LOCK   hold grant while hlock[owner] = 1. Return to ARB one hready edge after
//            hlock falls, which covers the trailing data phase.
//   Responses: hresp != OKAY with hready = 0 (first response cycle) forces FSM -> ARB and
//     clears beats. Re-arbitration happens on the following hready = 1 edge.
//     - SPLIT (11): set split_mask[hmaster_d] on that edge.
//     - RETRY (10): the same master may win again.
//   Split release: hsplit[i] = 1 clears split_mask[i] next edge, regardless of hready.
//     Simultaneous set and clear of the same bit: set wins.
//   Simultaneous requests: round-robin only, no fixed priority.
//   last_owner updates whenever hgrant changes.
//   No combinational path from inputs to outputs.
// STRUCTURE
//   ahb_pkg (shared): HTRANS_IDLE/BUSY/NONSEQ/SEQ, HBURST_* and HRESP_* localparams,
//     function burst_len(hburst) -> 1/4/8/16 (0 = undefined INCR).
//   Sub-module ahb_rr_pick: combinational round-robin picker (eligible, last_owner -> onehot).
//   The top holds the FSM, beat counter, split mask and ownership pipeline.
// TESTING
//   1. Reset; hbusreq = 00 -> hgrant = 01, hmaster = 0, hmastlock = 0.
//   2. hbusreq = 11 for 4 SINGLE transfers, hready = 1 -> hgrant alternates 10, 01, 10, 01;
//      hmaster lags hgrant by one cycle; hmaster_d lags hmaster by one cycle.
//   3. M0 INCR4 with M1 requesting, one BUSY inserted after beat 2 -> hgrant stays 01
//      through 3 address beats; becomes 10 during beat 4; hmaster = 1 one cycle later.
//   4. M1 hlock = 1 for 3 transfers, hbusreq = 11 -> grant held on M1;
//      hmastlock = 1 for those 3 address phases; M0 granted one hready edge after hlock drops.
//   5. M0 data phase gets SPLIT (cycle 1: hready = 0, hresp = 11) -> split_mask = 01, hgrant = 10.
//      With both masters masked, hgrant = 01 (DEF_MASTER). hsplit = 01 -> M0 eligible again.
//   6. hreset = 1 mid INCR8 (beats = 5) -> next edge all outputs at reset values,
//      FSM = ARB, beats = 0.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB encodings, arbiter state type and burst-length decode
// for the round-robin bus arbiter.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    typedef enum logic [1:0] {
        ST_ARB   = 2'b00,
        ST_BURST = 2'b01,
        ST_LOCK  = 2'b10
    } arb_state_e;

    // Beats in a burst; 0 marks an undefined-length INCR.
    function automatic logic [4:0] burst_len(input logic [2:0] hburst);
        logic [4:0] len;
        case (hburst)
            HBURST_SINGLE:                 len = 5'd1;
            HBURST_INCR:                   len = 5'd0;
            HBURST_WRAP4,  HBURST_INCR4:   len = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:   len = 5'd8;
            HBURST_WRAP16, HBURST_INCR16:  len = 5'd16;
            default:                       len = 5'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/ahb_rr_arbiter_pick.sv
// Combinational round-robin picker: first eligible master after i_last,
// wrapping; falls back to the default master when nothing is eligible.
module ahb_rr_pick #(
    parameter int NUM_MASTERS = 2,
    parameter int MW          = $clog2(NUM_MASTERS),
    parameter int DEF_MASTER  = 0
) (
    input  logic [NUM_MASTERS-1:0] i_eligible,
    input  logic [MW-1:0]          i_last,
    output logic [NUM_MASTERS-1:0] o_grant
);

    logic [MW:0] w_pos;
    logic        w_found;

    // Rotating search starting one past the last owner.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            w_pos = {1'b0, i_last} + (MW+1)'(k);
            if (w_pos >= (MW+1)'(NUM_MASTERS)) begin
                w_pos = w_pos - (MW+1)'(NUM_MASTERS);
            end else begin
                w_pos = w_pos;
            end
            if (!w_found && i_eligible[w_pos[MW-1:0]]) begin
                o_grant[w_pos[MW-1:0]] = 1'b1;
                w_found                = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
        if (!w_found) begin
            o_grant[DEF_MASTER] = 1'b1;
        end else begin
            o_grant = o_grant;
        end
    end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB arbiter: grant FSM with burst/lock hold, SPLIT masking
// and the address/data-phase ownership pipeline.
module ahb_rr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int MW          = $clog2(NUM_MASTERS),
    parameter int DEF_MASTER  = 0
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic                   hready,
    input  logic [1:0]             hresp,
    input  logic [NUM_MASTERS-1:0] hsplit,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [MW-1:0]          hmaster,
    output logic [MW-1:0]          hmaster_d,
    output logic                   hmastlock
);
    import ahb_pkg::*;

    localparam logic [NUM_MASTERS-1:0] DEF_OH =
        {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEF_MASTER;

    function automatic logic [MW-1:0] oh2idx(input logic [NUM_MASTERS-1:0] oh);
        logic [MW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (oh[i]) idx = MW'(i);
        end
        return idx;
    endfunction

    arb_state_e             r_state, w_state_nxt;
    logic [4:0]             r_beats, w_beats_nxt, w_len;
    logic [NUM_MASTERS-1:0] r_hgrant, w_grant_nxt, r_split_mask, w_split_set;
    logic [NUM_MASTERS-1:0] w_eligible, w_pick, w_hold;
    logic [MW-1:0]          r_hmaster, r_hmaster_d, w_grant_idx;
    logic                   r_hmastlock, w_resp_first;

    // Grant tracks last_owner implicitly: it only ever changes to the picked master.
    assign w_grant_idx  = oh2idx(r_hgrant);
    assign w_eligible   = hbusreq & ~r_split_mask;
    assign w_len        = burst_len(hburst);
    assign w_resp_first = (hresp != HRESP_OKAY) && !hready;

    ahb_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .MW          (MW),
        .DEF_MASTER  (DEF_MASTER)
    ) u_pick (
        .i_eligible (w_eligible),
        .i_last     (w_grant_idx),
        .o_grant    (w_pick)
    );

    // One-hot of the address-phase owner, used to pin the grant on a burst/lock start.
    always_comb begin
        w_hold            = '0;
        w_hold[r_hmaster] = 1'b1;
    end

    // Next-state, beat count and next grant.
    always_comb begin
        w_state_nxt = r_state;
        w_beats_nxt = r_beats;
        w_grant_nxt = r_hgrant;
        if (w_resp_first) begin
            w_state_nxt = ST_ARB;
            w_beats_nxt = 5'd0;
        end else if (hready) begin
            case (r_state)
                ST_ARB: begin
                    if ((htrans == HTRANS_NONSEQ) && (w_len > 5'd1)) begin
                        w_state_nxt = ST_BURST;
                        w_beats_nxt = w_len - 5'd1;
                        w_grant_nxt = w_hold;
                    end else if ((htrans == HTRANS_NONSEQ) && hlock[r_hmaster]) begin
                        w_state_nxt = ST_LOCK;
                        w_grant_nxt = w_hold;
                    end else begin
                        w_grant_nxt = w_pick;
                    end
                end
                ST_BURST: begin
                    // Re-arbitrate as the penultimate beat is accepted.
                    if (htrans == HTRANS_SEQ) begin
                        w_beats_nxt = r_beats - 5'd1;
                        if (r_beats <= 5'd2) begin
                            w_state_nxt = ST_ARB;
                            w_grant_nxt = w_pick;
                        end else begin
                            w_state_nxt = ST_BURST;
                        end
                    end else begin
                        w_beats_nxt = r_beats;
                    end
                end
                ST_LOCK: begin
                    if (!hlock[r_hmaster]) begin
                        w_state_nxt = ST_ARB;
                    end else begin
                        w_state_nxt = ST_LOCK;
                    end
                end
                default: begin
                    w_state_nxt = ST_ARB;
                    w_beats_nxt = 5'd0;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // FSM, beat counter and grant registers.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state  <= ST_ARB;
            r_beats  <= 5'd0;
            r_hgrant <= DEF_OH;
        end else begin
            r_state  <= w_state_nxt;
            r_beats  <= w_beats_nxt;
            r_hgrant <= w_grant_nxt;
        end
    end

    // Ownership pipeline advances only on accepted transfers.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_hmaster   <= MW'(DEF_MASTER);
            r_hmaster_d <= MW'(DEF_MASTER);
            r_hmastlock <= 1'b0;
        end else if (hready) begin
            r_hmaster   <= w_grant_idx;
            r_hmaster_d <= r_hmaster;
            r_hmastlock <= hlock[w_grant_idx];
        end
    end

    // SPLIT marks the data-phase owner; the set term is applied last so it wins.
    always_comb begin
        w_split_set = '0;
        if (w_resp_first && (hresp == HRESP_SPLIT)) begin
            w_split_set[r_hmaster_d] = 1'b1;
        end else begin
            w_split_set = '0;
        end
    end

    // Split mask register.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_split_mask <= '0;
        end else begin
            r_split_mask <= (r_split_mask & ~hsplit) | w_split_set;
        end
    end

    assign hgrant    = r_hgrant;
    assign hmaster   = r_hmaster;
    assign hmaster_d = r_hmaster_d;
    assign hmastlock = r_hmastlock;

endmodule
